// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the single register-file write port: the pipeline result (A) always wins,
// long-latency results (B) queue in a small FIFO, and a busy bitmap tracks registers still awaiting a B write.
module rf_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  input  logic [ADDR_WIDTH-1:0]      a_waddr,
  input  logic [DATA_WIDTH-1:0]      a_wdata,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [ADDR_WIDTH-1:0]      b_waddr,
  input  logic [DATA_WIDTH-1:0]      b_wdata,
  input  logic                       iss_valid,
  input  logic [ADDR_WIDTH-1:0]      iss_waddr,
  output logic [(2**ADDR_WIDTH)-1:0] busy,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata
);
  localparam int NREG  = 2**ADDR_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;

  logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  rf_wen_q, rf_wen_d, rf_from_b_q, rf_from_b_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]       busy_q, busy_d;
  logic                  a_sel, push, pop;
  logic [ENT_W-1:0]      head;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  assign b_ready  = (count_q != CNT_W'(FIFO_DEPTH));
  assign busy     = busy_q;
  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // FIFO bookkeeping: push on B handshake, pop whenever A leaves the port idle
  always_comb begin
    a_sel     = a_valid && (a_waddr != '0);
    push      = b_valid && b_ready;
    pop       = !a_sel && (count_q != '0);
    head      = mem_q[rd_ptr_q];
    head_addr = head[ENT_W-1:DATA_WIDTH];
    head_data = head[DATA_WIDTH-1:0];
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {b_waddr, b_wdata};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Write selection; address/data hold whenever no write is issued
  always_comb begin
    rf_wen_d    = 1'b0;
    rf_from_b_d = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    if (a_sel) begin
      rf_wen_d   = 1'b1;
      rf_waddr_d = a_waddr;
      rf_wdata_d = a_wdata;
    end else if (pop) begin
      // an x0 entry is still consumed, it just never reaches the register file
      rf_from_b_d = 1'b1;
      if (head_addr != '0) begin
        rf_wen_d   = 1'b1;
        rf_waddr_d = head_addr;
        rf_wdata_d = head_data;
      end else begin
        rf_wen_d = 1'b0;
      end
    end else begin
      rf_wen_d = 1'b0;
    end
  end

  // Scoreboard: clear on committed B write, then set on issue so a same-edge set wins
  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q && rf_from_b_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (iss_valid && (iss_waddr != '0)) begin
      busy_d[iss_waddr] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rf_wen_q    <= 1'b0;
      rf_from_b_q <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      busy_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rf_wen_q    <= rf_wen_d;
      rf_from_b_q <= rf_from_b_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      busy_q      <= busy_d;
    end
  end

  // FIFO storage needs no reset; occupancy alone marks entries as valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and pending-write scoreboard sitting directly upstream of the CPU register file's single write port. It merges two result streams into one registered write per cycle:
- the in-order pipeline result (port A, fixed priority, never stalled);
- long-latency results from loads and the multiplier/divider (port B, valid/ready, buffered in a small FIFO).

It also tracks which architectural registers have an outstanding port-B write, so decode can stall on them.

## Interface
Parameters:
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 5, register index width (32 registers)
- FIFO_DEPTH, 2, port-B buffer entries (power of two, ≥2)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- a_valid  input  1  pipeline result present this cycle
- a_waddr  input  ADDR_WIDTH  pipeline destination register
- a_wdata  input  DATA_WIDTH  pipeline result
- b_valid  input  1  long-latency result offered
- b_ready  output  1  FIFO can accept (= not full)
- b_waddr  input  ADDR_WIDTH  long-latency destination
- b_wdata  input  DATA_WIDTH  long-latency result
- iss_valid  input  1  long-latency op issued from decode
- iss_waddr  input  ADDR_WIDTH  its destination register
- busy  output  2^ADDR_WIDTH  per-register pending-write bitmap
- rf_wen  output  1  register file write enable
- rf_waddr  output  ADDR_WIDTH  register file write address
- rf_wdata  output  DATA_WIDTH  register file write data

## Operation
- **Port B:** accepted at a rising edge when b_valid && b_ready; the entry {waddr, wdata} is pushed into the FIFO. b_ready is combinational !full.
- **Selection each cycle, priority order:**
  1. a_valid && a_waddr!=0: port A selected; FIFO holds.
  2. Otherwise, FIFO non-empty: the head is popped and selected.
  3. Otherwise: no write.
- a_valid with a_waddr==0 counts as no write; the FIFO may drain that cycle.
- **Output register:** the selection is registered into rf_wen/rf_waddr/rf_wdata.
  - rf_wen=1 only if the selected address is non-zero.
  - A popped B entry with address 0 is consumed, with rf_wen=0.
  - When rf_wen=0, rf_waddr/rf_wdata hold their previous values.
- An internal flag rf_from_b is registered alongside, marking that the current rf_* write came from port B.
- **busy set:** busy[iss_waddr] is set at the edge when iss_valid && iss_waddr!=0.
- **busy clear:** busy[rf_waddr] is cleared at the edge where the register file commits a port-B write (rf_wen && rf_from_b). From the following cycle, the register file holds the value and busy is 0.
- Same register set and cleared at the same edge: set wins.
- busy[0] is always 0.
- FIFO push and pop in the same cycle: both take effect; occupancy is unchanged.
- Port A writes never touch busy. Decode guarantees no port-A write to a busy register; this is not checked.

## Timing
- **Reset values:** rf_wen=0, rf_waddr=0, rf_wdata=0, busy=0, FIFO empty, b_ready=1. Reset mid-operation discards all FIFO contents and pending bits; rst dominates all inputs.
- **Port A latency:** a_valid at cycle N gives rf_wen=1 in cycle N+1; the register file commits at the end of N+1.
- **Port B latency:** accepted at edge ending cycle N. Earliest pop is cycle N+1, rf_wen in N+2, busy clear at the edge ending N+2. There is no same-cycle bypass of an empty FIFO.
- **Starvation:** port B can starve while port A is continuously valid. FIFO fills, then b_ready=0; this is permitted.
- **Throughput:** at most one register write per cycle; a full FIFO with no port-A traffic drains one entry per cycle.
- busy is a registered output; no combinational path from inputs to busy or rf_*.

## Test plan
- **Reset:** rst=1 for 2 cycles with all valids high. Required: rf_wen=0, busy=0, b_ready=1 throughout. After release, the outputs reflect only post-reset inputs.
- **Port A alone:**
  - a_valid=1, a_waddr=5, a_wdata=0xDEADBEEF at cycle N. Required: cycle N+1 shows rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
  - a_waddr=0. Required: rf_wen=0.
- **Scoreboard round trip:**
  - iss_valid, iss_waddr=7 at cycle 0. Required: busy[7]=1 from cycle 1.
  - b_valid, waddr=7, wdata=0x1234 accepted at cycle 3. Required: rf_wen with waddr=7 in cycle 5; busy[7]=0 from cycle 6.
- **Priority and backpressure:**
  - a_valid held high for 4 cycles while port B offers 3 entries (regs 1, 2, 3). Required: b_ready drops after 2 accepts; no B write during A traffic.
  - After A drops, the B writes appear in order 1, 2, 3 on consecutive cycles; b_ready returns to 1.
- **Set/clear collision:** a port-B write to reg 9 commits at the same edge as iss_valid, iss_waddr=9. Required: busy[9] stays 1.
- **x0 handling:** iss_waddr=0 leaves busy unchanged. A B entry with waddr=0 is popped with rf_wen=0, and the FIFO count decrements.
